// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers (E stage).
//
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-low reset
//   start, op      one-cycle launch request and opcode:
//                  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//                  7 MADD, 8 MSUB; 9-15 NONE
//   a, b           rs / rt operands (forwarded E-stage values)
//   abort          cancel in-flight op, or a start in the same cycle
//   busy           multi-cycle op in progress
//   md_stall       combinational stall request for the hazard unit
//   hi, lo         HI/LO registers
//   done           one-cycle pulse when a multi-cycle op commits
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             md_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int W2   = 2 * WIDTH;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3,
        OP_DIVU = 4'd4, OP_MTHI = 4'd5, OP_MTLO = 4'd6, OP_MADD = 4'd7,
        OP_MSUB = 4'd8
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;

    logic is_multi, is_div;
    always_comb begin
        is_multi = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) ||
                   (op == OP_DIVU) || (op == OP_MADD)  || (op == OP_MSUB);
        is_div   = (op == OP_DIV) || (op == OP_DIVU);
    end

    assign busy     = (state == RUN);
    assign md_stall = busy | (start & is_multi);

    // Result datapath on the latched operands. Sign-extending to 2*WIDTH and
    // keeping the low 2*WIDTH product bits gives the exact signed product.
    logic [W2-1:0]    ext_a, ext_b, prod, acc;
    logic             a_neg, b_neg, sgn;
    logic [WIDTH-1:0] mag_a, mag_b, divisor, q_mag, r_mag;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             res_we;

    always_comb begin
        sgn     = (op_q == OP_DIV) || (op_q == OP_MULT) ||
                  (op_q == OP_MADD) || (op_q == OP_MSUB);
        ext_a   = sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b   = sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod    = ext_a * ext_b;
        acc     = {hi, lo};
        // Divide on magnitudes, then fix signs: quotient truncates toward
        // zero, remainder follows the dividend. MIN/-1 falls out naturally
        // as quotient MIN, remainder 0.
        a_neg   = sgn & a_q[WIDTH-1];
        b_neg   = sgn & b_q[WIDTH-1];
        mag_a   = a_neg ? -a_q : a_q;
        mag_b   = b_neg ? -b_q : b_q;
        divisor = (mag_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
        q_mag   = mag_a / divisor;
        r_mag   = mag_a % divisor;
        res_we  = 1'b1;
        res_hi  = prod[W2-1:WIDTH];
        res_lo  = prod[WIDTH-1:0];
        case (op_q)
            OP_MADD: {res_hi, res_lo} = acc + prod;
            OP_MSUB: {res_hi, res_lo} = acc - prod;
            OP_DIV, OP_DIVU: begin
                res_we = (b_q != '0);   // divide by zero leaves HI/LO alone
                res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
                res_hi = a_neg ? -r_mag : r_mag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (is_multi) begin
                            state <= RUN;
                            op_q  <= op;
                            a_q   <= a;
                            b_q   <= b;
                            cnt   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CW'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                        done  <= 1'b1;
                        if (res_we) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The hazard unit must never issue while busy.
    a_no_start_busy: assert property (@(posedge clk) disable iff (!reset) !(start && busy));

endmodule
